// File: rtl/cam_capture_rgb444_if.sv
// Frame-buffer write path: camera byte bus in, linear RGB444 write port out.
// The master is the capture stage. The slave is the camera and frame-buffer side.
interface cam_capture_rgb444_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;

    modport master (
        input  vsync, href, px_data,
        output addr_in, data_in, regwrite
    );

    modport slave (
        output vsync, href, px_data,
        input  addr_in, data_in, regwrite
    );
endinterface

// File: rtl/cam_capture_rgb444.sv
// Camera RGB565 byte-pair capture into a linear RGB444 frame-buffer write port; write strobe follows second byte by one cycle.
// No backpressure: the camera cannot be stalled, so pixels beyond MAX_PIX are dropped and flagged in a sticky overflow bit.
module cam_capture_rgb444 #(
    parameter int AW      = 15,
    parameter int DW      = 12,
    parameter int MAX_PIX = 19200
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 capture_en_i,
    input  logic                 single_shot_i,
    cam_capture_rgb444_if.master bus,
    output logic                 frame_done_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [AW-1:0]        pix_count_o
);
    typedef enum logic [1:0] {WAIT_FS, BYTE1, BYTE2, DONE} state_t;

    localparam logic [AW-1:0] MAX_C = AW'(MAX_PIX);

    state_t        state_q, state_d;
    logic          vsync_q, cen_q;
    logic          armed_q, armed_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    r_q, r_d;
    logic [2:0]    ghi_q, ghi_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          frame_start, frame_end;

    assign frame_start = vsync_q & ~bus.vsync;
    assign frame_end   = ~vsync_q & bus.vsync;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        data_d  = data_q;
        r_d     = r_q;
        ghi_d   = ghi_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ovf_d   = ovf_q;

        if (capture_en_i && !cen_q) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            WAIT_FS, DONE: begin
                state_d = WAIT_FS;
                if (frame_start && capture_en_i && armed_q) begin
                    state_d = BYTE1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            BYTE1, BYTE2: begin
                if (frame_end) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pix_d   = cnt_q;
                    busy_d  = 1'b0;
                    if (single_shot_i) begin
                        armed_d = 1'b0;
                    end
                end else if (frame_start) begin
                    // vsync glitch without a visible frame end: restart the frame silently
                    state_d = BYTE1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (state_q == BYTE1) begin
                    if (bus.href) begin
                        r_d     = bus.px_data[7:4];
                        ghi_d   = bus.px_data[2:0];
                        state_d = BYTE2;
                    end
                end else begin
                    // href low here means an odd byte count on the line; the half pixel is dropped
                    state_d = BYTE1;
                    if (bus.href) begin
                        if (cnt_q != MAX_C) begin
                            wr_d   = 1'b1;
                            addr_d = cnt_q;
                            data_d = DW'({r_q, ghi_q, bus.px_data[7], bus.px_data[4:1]});
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = WAIT_FS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT_FS;
            vsync_q <= 1'b1;
            cen_q   <= 1'b0;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
            data_q  <= '0;
            r_q     <= '0;
            ghi_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.vsync;
            cen_q   <= capture_en_i;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            r_q     <= r_d;
            ghi_q   <= ghi_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.addr_in  = addr_q;
    assign bus.data_in  = data_q;
    assign bus.regwrite = wr_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy_q;
    assign overflow_o   = ovf_q;
    assign pix_count_o  = pix_q;
endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Bench for cam_capture_rgb444: random camera frames against an RGB565->RGB444 pixel-stream model.
module tb_cam_capture_rgb444;
    localparam int AW       = 15;
    localparam int DW       = 12;
    localparam int MAXP     = 300;
    localparam int LINE_PIX = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic cen   = 1'b0;
    logic ss    = 1'b0;
    logic frame_done, busy, overflow;
    logic [AW-1:0] pix_count;

    cam_capture_rgb444_if #(.AW(AW), .DW(DW)) bus ();

    cam_capture_rgb444 #(.AW(AW), .DW(DW), .MAX_PIX(MAXP)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .capture_en_i (cen),
        .single_shot_i(ss),
        .bus          (bus.master),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .pix_count_o  (pix_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    // model state: what the pixel stream must produce
    bit         m_vsq, m_cen_prev, m_armed, m_cap, m_half;
    logic [7:0] m_b1;
    int         m_cnt;
    bit         exp_wr, exp_done, exp_busy, exp_ovf;
    int         exp_addr, exp_pix;
    logic [11:0] exp_data;

    int mon_wr = 0, mon_done = 0, mon_last = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [11:0] rgb444(input logic [7:0] b1, input logic [7:0] b2);
        int r5, g6, b5;
        r5 = int'(b1) / 8;
        g6 = (int'(b1) % 8) * 8 + int'(b2) / 32;
        b5 = int'(b2) % 32;
        return 12'((r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2));
    endfunction

    task automatic model_reset();
        m_vsq = 1'b1; m_cen_prev = 1'b0; m_armed = 1'b1; m_cap = 1'b0; m_half = 1'b0;
        m_b1 = 8'h00; m_cnt = 0;
        exp_wr = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_ovf = 1'b0;
        exp_addr = 0; exp_pix = 0; exp_data = 12'h000;
    endtask

    task automatic model_edge(input logic vs, input logic hr, input logic [7:0] d);
        bit fs, fe, arm0;
        fs = m_vsq && !vs;
        fe = !m_vsq && vs;
        arm0 = m_armed;
        exp_wr = 1'b0;
        exp_done = 1'b0;
        if (cen && !m_cen_prev) m_armed = 1'b1;
        if (m_cap && fe) begin
            exp_done = 1'b1; exp_pix = m_cnt; exp_busy = 1'b0; m_cap = 1'b0;
            if (ss) m_armed = 1'b0;
        end else if (fs && (m_cap || (cen && arm0))) begin
            m_cap = 1'b1; m_half = 1'b0; m_cnt = 0; exp_ovf = 1'b0; exp_busy = 1'b1;
        end else if (m_cap && hr && !m_half) begin
            m_b1 = d; m_half = 1'b1;
        end else if (m_cap && hr) begin
            m_half = 1'b0;
            if (m_cnt < MAXP) begin
                exp_wr = 1'b1; exp_addr = m_cnt; exp_data = rgb444(m_b1, d); m_cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (m_cap) begin
            m_half = 1'b0;
        end
        m_vsq = vs;
        m_cen_prev = cen;
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        bus.vsync = vs; bus.href = hr; bus.px_data = d;
        @(posedge clk);
        if (rst_n) model_edge(vs, hr, d);
        else model_reset();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("regwrite", 32'(bus.regwrite), 32'(exp_wr));
            if (exp_wr) begin
                chk("addr_in", 32'(bus.addr_in), 32'(exp_addr));
                chk("data_in", 32'(bus.data_in), 32'(exp_data));
            end
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("pix_count", 32'(pix_count), 32'(exp_pix));
            if (bus.regwrite) begin mon_wr++; mon_last = int'(bus.addr_in); end
            if (frame_done) mon_done++;
        end
    end

    // one camera frame; odd_line gets one extra byte, abort_pix>0 pulses reset after that pixel
    task automatic frame(input int nlines, input int odd_line, input int mode, input int abort_pix,
                         input int cen_drop_line);
        int pix, nb;
        logic [7:0] d;
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        pix = 0;
        for (int l = 0; l < nlines; l++) begin
            if (l == cen_drop_line) cen = 1'b0;
            nb = 2 * LINE_PIX + ((l == odd_line) ? 1 : 0);
            for (int b = 0; b < nb; b++) begin
                if (mode == 1) d = b[0] ? 8'h00 : 8'hF8;
                else d = 8'($urandom);
                tick(1'b0, 1'b1, d);
                if (b[0]) begin
                    pix++;
                    if (pix == abort_pix) begin
                        chk("pre_rst_wr", 32'(bus.regwrite), 32'd1);
                        rst_n = 1'b0;
                        #1;
                        chk("async_rst_wr", 32'(bus.regwrite), 32'd0);
                        chk("async_rst_busy", 32'(busy), 32'd0);
                        model_reset();
                        repeat (3) tick(1'b1, 1'b0, 8'h00);
                        rst_n = 1'b1;
                        return;
                    end
                    if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 8'h00);
                end
            end
            repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 8'h00);
        end
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int w0, d0;
        bus.vsync = 1'b1; bus.href = 1'b0; bus.px_data = 8'h00;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
        chk("rst_addr", 32'(bus.addr_in), 32'd0);
        chk("rst_data", 32'(bus.data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pix", 32'(pix_count), 32'd0);
        chk_on = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        rst_n = 1'b1;
        cen = 1'b1;
        tick(1'b1, 1'b0, 8'h00);

        // full frame of pure red
        w0 = mon_wr; d0 = mon_done;
        frame(15, -1, 1, -1, -1);
        chk("t1_writes", 32'(mon_wr - w0), 32'd300);
        chk("t1_done", 32'(mon_done - d0), 32'd1);
        chk("t1_last_addr", 32'(mon_last), 32'd299);
        chk("t1_pix", 32'(pix_count), 32'd300);

        // pure green then pure blue pixel
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h07);
        chk("t2_b1_nowr", 32'(bus.regwrite), 32'd0);
        tick(1'b0, 1'b1, 8'hE0);
        chk("t2_wr", 32'(bus.regwrite), 32'd1);
        chk("t2_green", 32'(bus.data_in), 32'h0F0);
        chk("t2_addr0", 32'(bus.addr_in), 32'd0);
        tick(1'b0, 1'b0, 8'h00);
        chk("t2_wr_once", 32'(bus.regwrite), 32'd0);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h1F);
        chk("t2_blue", 32'(bus.data_in), 32'h00F);
        chk("t2_addr1", 32'(bus.addr_in), 32'd1);
        tick(1'b1, 1'b0, 8'h00);
        chk("t2_done", 32'(frame_done), 32'd1);
        chk("t2_pix", 32'(pix_count), 32'd2);

        // odd-length first line
        w0 = mon_wr;
        frame(15, 0, 0, -1, -1);
        chk("t3_writes", 32'(mon_wr - w0), 32'd300);
        chk("t3_pix", 32'(pix_count), 32'd300);

        // overflow, then cleared by next frame start
        w0 = mon_wr;
        frame(16, -1, 0, -1, -1);
        chk("t4_writes", 32'(mon_wr - w0), 32'd300);
        chk("t4_last_addr", 32'(mon_last), 32'd299);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_pix", 32'(pix_count), 32'd300);
        frame(3, -1, 0, -1, -1);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) frame($urandom_range(1, 16), $urandom_range(0, 20), 0, -1, -1);

        // single shot: one of three frames, then re-arm
        ss = 1'b1;
        d0 = mon_done;
        frame(4, -1, 0, -1, -1);
        chk("t5_first", 32'(mon_done - d0), 32'd1);
        w0 = mon_wr; d0 = mon_done;
        frame(4, -1, 0, -1, -1);
        frame(4, -1, 0, -1, -1);
        chk("t5_skip_wr", 32'(mon_wr - w0), 32'd0);
        chk("t5_skip_done", 32'(mon_done - d0), 32'd0);
        cen = 1'b0; tick(1'b1, 1'b0, 8'h00);
        cen = 1'b1; tick(1'b1, 1'b0, 8'h00);
        d0 = mon_done;
        frame(4, -1, 0, -1, -1);
        chk("t5_rearm", 32'(mon_done - d0), 32'd1);
        ss = 1'b0;
        cen = 1'b0; tick(1'b1, 1'b0, 8'h00);
        cen = 1'b1; tick(1'b1, 1'b0, 8'h00);

        // capture_en dropped mid-frame still completes, and blocks the next frame
        d0 = mon_done;
        frame(6, -1, 0, -1, 2);
        chk("t5_cen_drop", 32'(mon_done - d0), 32'd1);
        frame(3, -1, 0, -1, -1);
        chk("t5_cen_off", 32'(mon_done - d0), 32'd1);
        cen = 1'b1; tick(1'b1, 1'b0, 8'h00);

        // reset mid-frame, then a clean full frame
        frame(15, -1, 0, 100, -1);
        w0 = mon_wr; d0 = mon_done;
        frame(15, -1, 0, -1, -1);
        chk("t6_writes", 32'(mon_wr - w0), 32'd300);
        chk("t6_done", 32'(mon_done - d0), 32'd1);
        chk("t6_pix", 32'(pix_count), 32'd300);

        repeat (3) tick(1'b1, 1'b0, 8'h00);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
